ram_writer: RTL
===============

Name: ram_writer

Overview:
- Fills the frame RAM from the serial link: accepts received bytes from the UART receiver, packs them MSB-first into RAM_WIDTH-bit words and issues single-cycle writes at sequential addresses 0..RAM_DEPTH-1.
- Write-side counterpart of the VGA display RAM read path. Sits between the UART receiver and the RAM write port.
- Shares the same word layout and address space as the read path, so a full frame written here is displayed unchanged.

Parameters:
- RAM_WIDTH, 32, word width in bits; must be a multiple of 8.
- RAM_DEPTH, (480*360*24)/RAM_WIDTH = 129600, number of words per frame.
- TIMEOUT_CYCLES, 50000, idle clk cycles after which a partially assembled word is discarded.
- Derived constants (not overridable):
  - ADDRESS_BITS = $clog2(RAM_DEPTH) = 17.
  - BYTES_PER_WORD = RAM_WIDTH/8 = 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new frame at address 0.
- rx_data  in  8  received byte; valid when rx_ready=1.
- rx_ready  in  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- adress  out  ADDRESS_BITS  RAM write address.
- data_out  out  RAM_WIDTH  RAM write data.
- write_enable  out  1  one-cycle RAM write strobe.
- busy  out  1  high in COLLECT.
- frame_done  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - adress=0, data_out=0, write_enable=0.
  - byte count=0, shift register=0, timeout counter=0.
  - busy=0, frame_done=0.
- States: IDLE, COLLECT, DONE. busy and frame_done are registered decodes of the state.
- Transitions:
  - IDLE -> COLLECT on start.
  - COLLECT -> COLLECT on start: restart. adress=0, byte count=0, partial word dropped.
  - COLLECT -> DONE on the edge ending the write_enable pulse for address RAM_DEPTH-1.
  - DONE -> COLLECT on start: adress=0, byte count=0.
- Entry to COLLECT always clears the byte count, the shift register and the timeout counter.
- Byte acceptance (COLLECT only):
  - Each rx_ready=1 cycle appends rx_data to the shift register and increments the byte count.
  - The first byte of a word lands in bits [RAM_WIDTH-1:RAM_WIDTH-8]; the last byte lands in [7:0].
  - rx_ready in IDLE or DONE is ignored.
- Word write:
  - If the byte completing a word is accepted at cycle N, then at cycle N+1 write_enable=1 and data_out holds the full word.
  - adress holds the current word index during that cycle.
  - write_enable is high for exactly one cycle.
  - adress increments on the edge ending the write_enable cycle, so the new value is visible at N+2.
  - The byte count wraps to 0 at cycle N+1, so a byte arriving at N+1 is byte 0 of the next word.
- data_out holds its last written value between writes. write_enable=0 outside write cycles.
- Address end:
  - After the write to RAM_DEPTH-1, adress holds RAM_DEPTH-1 and does not wrap.
  - The state moves to DONE.
  - Further bytes are ignored until start.
- Timeout:
  - The counter runs only in COLLECT with byte count != 0. It clears on every accepted byte.
  - On reaching TIMEOUT_CYCLES-1, the byte count and shift register are cleared. adress is unchanged, no write occurs, and the state remains COLLECT.
- Simultaneous events:
  - start with rx_ready in the same cycle: start wins and the byte is discarded.
  - start in the same cycle as a pending write_enable: the write still completes on that cycle, then adress=0.
  - Timeout expiry and rx_ready in the same cycle: the byte is accepted as byte 0 of a fresh word.
- Reset mid-frame immediately returns all outputs to reset values. An in-flight write_enable is aborted.

Test Plan:
Parameters for the bench are RAM_DEPTH=4, TIMEOUT_CYCLES=16.
- Reset, then start, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles -> one write_enable pulse, one cycle after 0x44, with adress=0 and data_out=0x11223344; adress=1 on the next cycle.
- 16 bytes 0x00..0x0F with gaps of 3 cycles -> 4 writes at adress 0..3 with data 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; then frame_done=1, busy=0, adress=3; an extra byte 0xFF produces no write.
- Start, bytes 0xAA,0xBB, 20 idle cycles, then 0x01,0x02,0x03,0x04 -> single write at adress=0 with data 0x01020304; no write containing 0xAA.
- Start, bytes 0x01,0x02, then start asserted together with rx_ready carrying 0x03, then 0x05,0x06,0x07,0x08 -> 0x03 is dropped; single write at adress=0 with data 0x05060708.
- Bytes sent before any start, in IDLE -> no write_enable, busy=0; after start and 4 bytes, the write goes to adress=0.
- rst asserted mid-word, asynchronously between clock edges -> all outputs read 0 immediately; after release, start and 4 bytes write to adress=0.

Source files
------------

// File: rtl/ram_writer.sv
// Packs UART bytes MSB-first into RAM words and writes them at sequential frame addresses.
// Write strobe one cycle after the completing byte; no backpressure, every strobed byte is taken in COLLECT.
module ram_writer #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = (480*360*24)/RAM_WIDTH,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_ready,
    output logic [$clog2(RAM_DEPTH)-1:0] adress,
    output logic [RAM_WIDTH-1:0]         data_out,
    output logic                         write_enable,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int ADDRESS_BITS   = $clog2(RAM_DEPTH);
    localparam int BYTES_PER_WORD = RAM_WIDTH/8;
    localparam int CNT_BITS       = $clog2(BYTES_PER_WORD) + 1;
    localparam int TMO_BITS       = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

    state_e                  state_q;
    logic [ADDRESS_BITS-1:0] adress_q;
    logic [RAM_WIDTH-1:0]    data_q;
    logic [RAM_WIDTH-1:0]    shift_q;
    logic [CNT_BITS-1:0]     cnt_q;
    logic [TMO_BITS-1:0]     tmo_q;
    logic                    we_q;
    logic                    busy_q;
    logic                    done_q;

    logic                    expire;
    logic                    word_done;
    logic                    last_addr;
    logic [CNT_BITS-1:0]     cnt_base;
    logic [RAM_WIDTH-1:0]    shift_base;
    logic [RAM_WIDTH-1:0]    shift_d;

    // An expiring partial word is dropped before a byte in the same cycle is appended.
    assign expire     = (cnt_q != '0) && (tmo_q == TMO_BITS'(TIMEOUT_CYCLES - 1));
    assign cnt_base   = expire ? '0 : cnt_q;
    assign shift_base = expire ? '0 : shift_q;
    assign shift_d    = (shift_base << 8) | RAM_WIDTH'(rx_data);
    assign word_done  = (cnt_base == CNT_BITS'(BYTES_PER_WORD - 1));
    assign last_addr  = (adress_q == ADDRESS_BITS'(RAM_DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            adress_q <= '0;
            data_q   <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                // A write strobed this cycle has already been presented; only the address rewinds.
                state_q  <= COLLECT;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
                adress_q <= '0;
                shift_q  <= '0;
                cnt_q    <= '0;
                tmo_q    <= '0;
            end else if (state_q == COLLECT) begin
                if (we_q) begin
                    if (last_addr) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        adress_q <= adress_q + ADDRESS_BITS'(1);
                    end
                end
                if (rx_ready) begin
                    tmo_q <= '0;
                    if (word_done) begin
                        data_q  <= shift_d;
                        we_q    <= 1'b1;
                        shift_q <= '0;
                        cnt_q   <= '0;
                    end else begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_base + CNT_BITS'(1);
                    end
                end else if (expire) begin
                    shift_q <= '0;
                    cnt_q   <= '0;
                    tmo_q   <= '0;
                end else if (cnt_q != '0) begin
                    tmo_q <= tmo_q + TMO_BITS'(1);
                end
            end
        end
    end

    assign adress       = adress_q;
    assign data_out     = data_q;
    assign write_enable = we_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;

endmodule
